apb_slave_mem: RTL and testbench
================================

// Module: apb_slave_mem
// PURPOSE
//  APB completer (slave) at the far end of our AHB-to-APB bridge: one psel line of the bridge
//  drives one instance. Holds a DEPTH x 32 register bank, serves APB read/write with
//  WAIT_STATES wait cycles, and flags out-of-range addresses (pslverr) and protocol violations
//  (prot_err). Sits on the APB segment; used as bridge test target and as a generic config bank.
// PARAMETERS
//  DEPTH        16   number of 32-bit words; power of 2, 2..256
//  WAIT_STATES  0    pready-low cycles in each access phase, 0..15
// PORTS
//  hclk      in   1   clock; all state on rising edge
//  hreset    in   1   asynchronous, active-high reset
//  psel      in   1   select for this completer (one bit of bridge psel bus)
//  penable   in   1   APB access-phase strobe
//  pwrite    in   1   1 = write, 0 = read
//  paddr     in   32  byte address; word index = paddr[31:2]
//  pwdata    in   32  write data
//  prdata    out  32  read data; valid when pready=1 on a read
//  pready    out  1   transfer completes in the cycle pready=1
//  pslverr   out  1   error response, valid only with pready=1
//  prot_err  out  1   sticky protocol-violation flag
//  xfer_cnt  out  16  completed-transfer count (incl. error ones), wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, prdata=0, pready=0, pslverr=0, prot_err=0,
//   xfer_cnt=0, all DEPTH words=0. Reset mid-access aborts the transfer; no write occurs.
//  FSM: IDLE, ACCESS.
//   IDLE:   psel=1 & penable=0 (setup) -> latch paddr, pwrite, pwdata; load wait ctr=WAIT_STATES;
//           range check (paddr[31:2] >= DEPTH => err). Read in range: prdata <= mem[idx] on this
//           edge; read out of range: prdata <= 0. -> ACCESS.
//           psel=1 & penable=1 (access without setup) -> prot_err<=1, stay IDLE, no effect.
//           psel=0 -> stay IDLE.
//   ACCESS: requires psel=1 & penable=1 each cycle.
//           ctr!=0: pready=0, ctr decrements.
//           ctr==0: pready=1, pslverr=err; on this edge: write in range -> mem[idx]<=latched
//             pwdata; out-of-range write discarded; xfer_cnt+1; -> IDLE.
//           psel=0 or penable=0 before completion -> prot_err<=1, abort (no write,
//             no count), -> IDLE same edge; dropped cycle is then evaluated as IDLE.
//  pready, pslverr combinational from state/ctr/err: high only in ACCESS with ctr==0.
//  Latched paddr/pwrite/pwdata used throughout ACCESS; bus changes mid-access ignored.
//  Latency: setup cycle + WAIT_STATES + 1 access cycle = WAIT_STATES+2 cycles per transfer.
//  Back-to-back: cycle after completion may be the next setup; IDLE handles it, no bubble.
//  prdata holds its value until the next read setup; writes do not change it.
//  prot_err clears only on reset.
// TESTING
//  WAIT_STATES=0: write 0xDEADBEEF @0x08, then read 0x08 -> each 2 cycles, pready=1 in access,
//   prdata=0xDEADBEEF, pslverr=0, xfer_cnt=2.
//  WAIT_STATES=3: read 0x04 after write 0x12345678 -> pready low 3 access cycles, high on 4th,
//   prdata=0x12345678.
//  DEPTH=16: write 0xFFFFFFFF @0x40 -> pslverr=1 with pready; read 0x3C unchanged; read 0x40
//   -> prdata=0, pslverr=1.
//  Back-to-back writes 0x00..0x3C (data=addr) then reads -> no idle gaps, all data match,
//   xfer_cnt=32.
//  psel=1,penable=1 with no setup -> prot_err=1, no memory change; WAIT_STATES=2, drop penable
//   mid-wait -> write aborted, xfer_cnt unchanged.
//  hreset pulse during ACCESS of write 0xA5A5A5A5 @0x0C -> outputs zero immediately, read
//   0x0C returns 0.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB completer with a DEPTH x 32 register bank, programmable wait states,
// out-of-range error response and a sticky protocol-violation flag.
module apb_slave_mem #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   output logic        prot_err,
   output logic [15:0] xfer_cnt
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t        state, state_nxt;
   logic [3:0]    ctr;
   logic          err_l;
   logic          wr_l;
   logic [AW-1:0] idx_l;
   logic [31:0]   wdata_l;
   logic [31:0]   mem [DEPTH];

   logic          setup, tick, complete, viol;
   logic          addr_oor;
   logic [AW-1:0] idx;
   logic          unused_addr;

   assign addr_oor    = (paddr[31:2] >= 30'(DEPTH));
   assign idx         = paddr[AW+1:2];
   assign unused_addr = ^paddr[1:0];

   always_comb begin
      state_nxt = state;
      pready    = 1'b0;
      pslverr   = 1'b0;
      setup     = 1'b0;
      tick      = 1'b0;
      complete  = 1'b0;
      viol      = 1'b0;
      case (state)
         IDLE: begin
            if (psel && !penable) begin
               setup     = 1'b1;
               state_nxt = ACCESS;
            end else if (psel && penable) begin
               viol = 1'b1;
            end
         end
         ACCESS: begin
            if (!psel || !penable) begin
               // Abort, then treat this same cycle as an IDLE cycle (may be a new setup).
               viol      = 1'b1;
               state_nxt = IDLE;
               if (psel && !penable) begin
                  setup     = 1'b1;
                  state_nxt = ACCESS;
               end
            end else if (ctr != 4'd0) begin
               tick = 1'b1;
            end else begin
               pready    = 1'b1;
               pslverr   = err_l;
               complete  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state    <= IDLE;
         ctr      <= '0;
         err_l    <= 1'b0;
         wr_l     <= 1'b0;
         idx_l    <= '0;
         wdata_l  <= '0;
         prdata   <= '0;
         prot_err <= 1'b0;
         xfer_cnt <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         state <= state_nxt;
         if (viol) begin
            prot_err <= 1'b1;
         end
         if (setup) begin
            idx_l   <= idx;
            wr_l    <= pwrite;
            wdata_l <= pwdata;
            err_l   <= addr_oor;
            ctr     <= 4'(WAIT_STATES);
            if (!pwrite) begin
               prdata <= addr_oor ? '0 : mem[idx];
            end
         end else if (tick) begin
            ctr <= ctr - 4'd1;
         end
         if (complete) begin
            if (wr_l && !err_l) begin
               mem[idx_l] <= wdata_l;
            end
            xfer_cnt <= xfer_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two completers (0 and 3 wait states) on one APB segment,
// directed and random transfers checked against an array-based reference model.
module tb_apb_slave_mem;

   logic        hclk = 1'b0;
   logic        hreset;
   logic [1:0]  psel;
   logic        penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] prdata   [2];
   logic        pready   [2];
   logic        pslverr  [2];
   logic        prot_err [2];
   logic [15:0] xfer_cnt [2];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   logic [31:0] mdl [2][16];
   logic [31:0] mp   [2];
   int          cnt  [2];
   logic        perr [2];

   always #5 hclk = ~hclk;
   always @(posedge hclk) cyc <= cyc + 1;

   apb_slave_mem #(.DEPTH(16), .WAIT_STATES(0)) u_ws0 (
      .hclk(hclk), .hreset(hreset), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]),
      .pslverr(pslverr[0]), .prot_err(prot_err[0]), .xfer_cnt(xfer_cnt[0]));

   apb_slave_mem #(.DEPTH(16), .WAIT_STATES(3)) u_ws3 (
      .hclk(hclk), .hreset(hreset), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]),
      .pslverr(pslverr[1]), .prot_err(prot_err[1]), .xfer_cnt(xfer_cnt[1]));

   function automatic int ws(input int t);
      return (t == 1) ? 3 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int t = 0; t < 2; t++) begin
         for (int w = 0; w < 16; w++) mdl[t][w] = '0;
         mp[t]   = '0;
         cnt[t]  = 0;
         perr[t] = 1'b0;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      for (int t = 0; t < 2; t++) begin
         chk({tag, "_prdata"},   prdata[t], 32'h0);
         chk({tag, "_pready"},   32'(pready[t]), 32'h0);
         chk({tag, "_pslverr"},  32'(pslverr[t]), 32'h0);
         chk({tag, "_prot_err"}, 32'(prot_err[t]), 32'h0);
         chk({tag, "_xfer_cnt"}, 32'(xfer_cnt[t]), 32'h0);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the completing edge.
   task automatic xfer(input int t, input bit wr, input logic [31:0] addr, input logic [31:0] data);
      int   start, waits;
      bit   done, oor;
      oor     = (addr[31:2] >= 30'd16);
      psel    = '0;
      psel[t] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      start   = cyc;
      if (!wr) mp[t] = oor ? 32'h0 : mdl[t][addr[5:2]];
      @(posedge hclk); #1;
      penable = 1'b1;
      paddr   = $urandom;
      pwdata  = $urandom;
      pwrite  = 1'($urandom);
      waits = 0;
      done  = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge hclk);
         if (pready[t]) begin
            done = 1'b1;
            break;
         end
         waits++;
         @(posedge hclk); #1;
      end
      chk("done", 32'(done), 32'h1);
      chk("wait_cycles", 32'(waits), 32'(ws(t)));
      chk("pslverr", 32'(pslverr[t]), 32'(oor));
      chk("prdata", prdata[t], mp[t]);
      @(posedge hclk); #1;
      if (wr && !oor) mdl[t][addr[5:2]] = data;
      cnt[t]++;
      chk("latency", 32'(cyc - start), 32'(ws(t) + 2));
      chk("xfer_cnt", 32'(xfer_cnt[t]), 32'(cnt[t] & 16'hFFFF));
      chk("prot_err", 32'(prot_err[t]), 32'(perr[t]));
      chk("pready_after", 32'(pready[t]), 32'h0);
      psel    = '0;
      penable = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      int          t;
      bit          wr;

      hreset  = 1'b1;
      psel    = '0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      model_reset();
      repeat (3) @(posedge hclk);
      #1;
      chk_reset_outputs("reset");
      @(negedge hclk);
      hreset = 1'b0;
      @(posedge hclk); #1;

      for (int i = 0; i < 16; i++) xfer(0, 1'b1, 32'(i * 4), 32'(i * 4));
      for (int i = 0; i < 16; i++) xfer(0, 1'b0, 32'(i * 4), 32'h0);
      chk("b2b_count", 32'(xfer_cnt[0]), 32'd32);

      xfer(0, 1'b1, 32'h08, 32'hDEADBEEF);
      xfer(0, 1'b0, 32'h08, 32'h0);
      chk("ws0_read", prdata[0], 32'hDEADBEEF);

      xfer(1, 1'b1, 32'h04, 32'h12345678);
      xfer(1, 1'b0, 32'h04, 32'h0);
      chk("ws3_read", prdata[1], 32'h12345678);

      xfer(1, 1'b1, 32'h3C, 32'h0BADF00D);
      xfer(1, 1'b1, 32'h40, 32'hFFFFFFFF);
      xfer(1, 1'b0, 32'h3C, 32'h0);
      xfer(1, 1'b0, 32'h40, 32'h0);
      xfer(0, 1'b1, 32'h8000_0000, 32'h1111_2222);
      xfer(0, 1'b0, 32'h8000_0000, 32'h0);
      xfer(0, 1'b0, 32'h0, 32'h0);

      for (int n = 0; n < 60; n++) begin
         t  = int'($urandom_range(0, 1));
         wr = 1'($urandom);
         a  = 32'($urandom_range(0, 19)) * 32'd4;
         if ($urandom_range(0, 9) == 0) a[31] = 1'b1;
         d  = $urandom;
         xfer(t, wr, a, d);
      end

      // Access phase with no setup on completer 0.
      psel    = 2'b01;
      penable = 1'b1;
      pwrite  = 1'b1;
      paddr   = 32'h08;
      pwdata  = 32'h0000_0BAD;
      @(posedge hclk); #1;
      perr[0] = 1'b1;
      psel    = '0;
      penable = 1'b0;
      chk("noset_prot", 32'(prot_err[0]), 32'h1);
      chk("noset_other", 32'(prot_err[1]), 32'h0);
      chk("noset_cnt", 32'(xfer_cnt[0]), 32'(cnt[0]));
      @(posedge hclk); #1;
      xfer(0, 1'b0, 32'h08, 32'h0);

      // Drop penable during wait states on completer 1.
      psel    = 2'b10;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h10;
      pwdata  = 32'h55AA_55AA;
      @(posedge hclk); #1;
      penable = 1'b1;
      @(posedge hclk); #1;
      penable = 1'b0;
      @(posedge hclk); #1;
      psel = '0;
      repeat (2) @(posedge hclk);
      #1;
      perr[1] = 1'b1;
      chk("drop_prot", 32'(prot_err[1]), 32'h1);
      chk("drop_cnt", 32'(xfer_cnt[1]), 32'(cnt[1]));
      xfer(1, 1'b0, 32'h10, 32'h0);

      // Reset pulse during the access phase of a write.
      psel    = 2'b10;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h0C;
      pwdata  = 32'hA5A5A5A5;
      @(posedge hclk); #1;
      penable = 1'b1;
      @(posedge hclk); #2;
      hreset = 1'b1;
      #1;
      model_reset();
      chk_reset_outputs("midreset");
      psel    = '0;
      penable = 1'b0;
      @(negedge hclk);
      hreset = 1'b0;
      @(posedge hclk); #1;
      xfer(1, 1'b0, 32'h0C, 32'h0);
      chk("midreset_read", prdata[1], 32'h0);
      xfer(0, 1'b0, 32'h0C, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
